// File: rtl/rom_stream_reader_if.sv
// ROM read bus plus valid/ready word stream between the reader, the ROM and the consumer.
interface rom_stream_reader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    modport master (
        output rom_en, rom_addr, out_valid, out_data, out_last,
        input  rom_data, out_ready
    );

    modport slave (
        input  rom_en, rom_addr, out_valid, out_data, out_last,
        output rom_data, out_ready
    );
endinterface

// File: rtl/rom_stream_reader.sv
// Walks a contiguous ROM address range after a start pulse, buffers the returned
// words in a small FIFO and streams them out with last-word marking and a done pulse.
module rom_stream_reader #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    rom_stream_reader_if.master bus
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W:0]   len_q, remaining_q, popped_q;
    logic [ADDR_W-1:0] addr_nxt_q, rom_addr_p0;
    logic              en_p0, vld_p1;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    logic              issue, push, pop, last_pop;
    logic              out_valid_w, out_last_w;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy includes reads still in flight so a full FIFO can never be overrun.
    always_comb begin
        occ         = {1'b0, count} + (CW+1)'(en_p0) + (CW+1)'(vld_p1);
        issue       = (state == RUN) && (remaining_q != '0) && (occ < DEPTH_C);
        push        = vld_p1;
        out_valid_w = (count != '0);
        out_last_w  = out_valid_w && (popped_q == len_q - 1'b1);
        pop         = out_valid_w && bus.out_ready;
        last_pop    = pop && out_last_w;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (length == '0) ? FIN : RUN;
            RUN:     if (last_pop) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == FIN);
    end

    // Stage p0: read issue towards the ROM.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            len_q       <= '0;
            remaining_q <= '0;
            addr_nxt_q  <= '0;
            rom_addr_p0 <= '0;
            en_p0       <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                len_q       <= length;
                remaining_q <= length;
                addr_nxt_q  <= start_addr;
            end else if (issue) begin
                remaining_q <= remaining_q - 1'b1;
                addr_nxt_q  <= addr_nxt_q + 1'b1;
                rom_addr_p0 <= addr_nxt_q;
            end
            en_p0  <= issue;
            vld_p1 <= en_p0;
        end
    end

    // Stage p1: ROM word returns and is written into the FIFO.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= bus.rom_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            popped_q <= '0;
        end else begin
            if ((state == IDLE) && start) popped_q <= '0;
            else if (pop)                 popped_q <= popped_q + 1'b1;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.rom_en    = en_p0;
    assign bus.rom_addr  = rom_addr_p0;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = out_valid_w ? mem[rd_ptr] : '0;
    assign bus.out_last  = out_last_w;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Bench for rom_stream_reader: ROM model returns ~addr, expected stream built from address arithmetic.
module tb_rom_stream_reader;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] start_addr;
    logic [4:0] length;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    rom_stream_reader_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    rom_stream_reader #(.ADDR_W(4), .DATA_W(4), .FIFO_DEPTH(4)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    // ROM: 1-cycle synchronous read of ~addr; garbage on the bus when not enabled.
    always @(posedge clock) begin
        if (bus.rom_en) bus.rom_data <= ~bus.rom_addr;
        else            bus.rom_data <= 4'($urandom);
    end

    typedef struct packed {
        logic [3:0] sa;
        logic [4:0] len;
        int         mode;     // 0: ready=1, 1: random ready, 2: ready=0 for 10 cycles
        logic [3:0] first;
        int         restart;  // cycle index of a stray start pulse, -1 for none
    } vec_t;

    vec_t vecs[8];

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input logic [3:0] sa, input logic [4:0] len, input int mode,
                            input logic [3:0] first_exp, input int restart_at);
        logic [3:0] q[$];
        logic [3:0] a;
        int k, done_at, issued, accepted, last_acc_k, first_en, first_valid;
        logic [3:0] first_data;
        for (int i = 0; i < int'(len); i++) begin
            a = sa + 4'(i);
            q.push_back(~a);
        end
        start = 1'b1; start_addr = sa; length = len;
        @(negedge clock);
        start = 1'b0;
        k = 0; done_at = (len == 0) ? 0 : -1; issued = 0; accepted = 0;
        last_acc_k = -1; first_en = -1; first_valid = -1; first_data = '0;
        while (1) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = (k >= 10);
            endcase
            if (k == restart_at && (done_at < 0 || k <= done_at)) begin
                start = 1'b1; start_addr = ~sa; length = 5'd3;
            end else begin
                start = 1'b0;
            end
            if (bus.rom_en) begin
                if (first_en < 0) first_en = k;
                a = sa + 4'(issued);
                check(bus.rom_addr == a, "rom_addr", bus.rom_addr, a);
                issued++;
                check(issued - accepted <= 4, "in_flight_limit", issued - accepted, 4);
                check(issued <= int'(len), "extra_read", issued, len);
            end
            if (bus.out_valid) begin
                if (first_valid < 0) begin first_valid = k; first_data = bus.out_data; end
                if (q.size() == 0) begin
                    check(0, "extra_word", bus.out_data, 0);
                end else begin
                    check(bus.out_data == q[0], "out_data", bus.out_data, q[0]);
                    check(bus.out_last == (q.size() == 1), "out_last", bus.out_last, q.size() == 1);
                    if (bus.out_ready) begin
                        if (mode == 0 && last_acc_k >= 0)
                            check(k == last_acc_k + 1, "bubble", k, last_acc_k + 1);
                        last_acc_k = k;
                        void'(q.pop_front());
                        accepted++;
                        if (q.size() == 0) done_at = k + 1;
                    end
                end
            end
            if (done || k == done_at) check(done == (k == done_at), "done", done, k == done_at);
            check(busy == (done_at < 0 || k < done_at), "busy", busy, done_at < 0 || k < done_at);
            if (mode == 2 && k == 9 && len >= 4) check(issued == 4, "stall_reads", issued, 4);
            if (done_at >= 0 && k == done_at + 1) break;
            if (k >= 300) begin
                check(0, "timeout", k, 300);
                break;
            end
            k++;
            @(negedge clock);
        end
        start = 1'b0;
        check(issued == int'(len), "reads_total", issued, len);
        check(q.size() == 0, "words_left", q.size(), 0);
        if (len == 0) begin
            check(first_en < 0 && first_valid < 0, "zero_len_quiet", first_valid, -1);
        end else begin
            check(first_data == first_exp, "first_word", first_data, first_exp);
            if (mode == 0) begin
                check(first_en == 1, "rom_en_latency", first_en, 1);
                check(first_valid == 3, "valid_latency", first_valid, 3);
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check({busy, done, bus.rom_en, bus.rom_addr, bus.out_valid, bus.out_data, bus.out_last} == '0,
              name, {busy, done, bus.rom_en, bus.rom_addr, bus.out_valid, bus.out_data, bus.out_last}, 0);
    endtask

    initial begin
        vecs[0] = '{4'h2, 5'd3,  0, 4'hD, -1};
        vecs[1] = '{4'hE, 5'd4,  0, 4'h1, -1};
        vecs[2] = '{4'h0, 5'd8,  2, 4'hF, -1};
        vecs[3] = '{4'h5, 5'd16, 0, 4'hA, -1};
        vecs[4] = '{4'h0, 5'd0,  0, 4'h0, -1};
        vecs[5] = '{4'hF, 5'd1,  0, 4'h0, -1};
        vecs[6] = '{4'h7, 5'd5,  1, 4'h8, -1};
        vecs[7] = '{4'h3, 5'd6,  0, 4'hC,  2};

        reset_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; bus.out_ready = 1'b0;
        #2;
        check_all_zero("reset_state");
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++)
            run_xfer(vecs[i].sa, vecs[i].len, vecs[i].mode, vecs[i].first, vecs[i].restart);

        // Reset in the middle of a transfer.
        start = 1'b1; start_addr = 4'h0; length = 5'd8; bus.out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check(bus.out_valid == 1'b1, "pre_reset_valid", bus.out_valid, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            check({busy, done, bus.rom_en, bus.out_valid} == 4'b0, "post_reset_quiet",
                  {busy, done, bus.rom_en, bus.out_valid}, 0);
        end

        for (int r = 0; r < 25; r++) begin
            logic [3:0] sa;
            logic [4:0] len;
            int ra;
            sa  = 4'($urandom);
            len = 5'($urandom_range(0, 16));
            ra  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
            run_xfer(sa, len, int'($urandom_range(0, 2)), ~sa, ra);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
